// File: rtl/minialu_arb.sv
// minialu_arb: two-requester round-robin front end for a shared iterative
// multiply (repeated add) / divide (repeated subtract) engine.
// Results are returned on one response port, tagged with the requester id.
// Optional build macro: MINIALU_ARB_SWAP_EN -- for multiply, count down the
// smaller operand and add the larger one, so the multiply latency is set by
// min(A,B) instead of B. Results are the same either way.
module minialu_arb #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [1:0]       r0_op,
  input  logic [W-1:0]     r0_a,
  input  logic [W-1:0]     r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [1:0]       r1_op,
  input  logic [W-1:0]     r1_a,
  input  logic [W-1:0]     r1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [2*W-1:0]   rsp_prd,
  output logic [W-1:0]     rsp_quo,
  output logic [W-1:0]     rsp_rem,
  output logic             rsp_err
);

  localparam logic [1:0]   OP_MUL = 2'b10;
  localparam logic [1:0]   OP_DIV = 2'b11;
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched operation and engine accumulators.
  logic             r_last;   // requester granted most recently
  logic             r_id;
  logic [1:0]       r_op;
  logic [W-1:0]     r_add;    // multiply addend
  logic [W-1:0]     r_cnt;    // multiply step counter
  logic [W-1:0]     r_b;      // divisor
  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_rem;
  logic [2*W-1:0]   r_prd;
  logic             r_err;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc;
  logic [1:0]       w_sel_op;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic [W-1:0]     w_mul_cnt;
  logic [W-1:0]     w_mul_add;

  // Round-robin pick: a lone valid requester wins; on a tie the one not
  // granted last wins. Grants only exist in IDLE and never during reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst && r_state == IDLE) begin
      if (r0_valid && (!r1_valid || r_last)) begin
        w_gnt0 = 1'b1;
      end else if (r1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign r0_ready = w_gnt0;
  assign r1_ready = w_gnt1;
  assign w_acc    = w_gnt0 | w_gnt1;

  assign w_sel_op = w_gnt1 ? r1_op : r0_op;
  assign w_sel_a  = w_gnt1 ? r1_a  : r0_a;
  assign w_sel_b  = w_gnt1 ? r1_b  : r0_b;

`ifdef MINIALU_ARB_SWAP_EN
  logic w_a_lt_b;
  assign w_a_lt_b  = (w_sel_a < w_sel_b);
  assign w_mul_cnt = w_a_lt_b ? w_sel_a : w_sel_b;
  assign w_mul_add = w_a_lt_b ? w_sel_b : w_sel_a;
`else
  assign w_mul_cnt = w_sel_b;
  assign w_mul_add = w_sel_a;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: RUN ends when the multiply counter is exhausted, the
  // remainder drops below the divisor (or the divisor is zero), or at once
  // for an illegal opcode; DONE waits for the consumer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_op == OP_MUL) begin
          if (r_cnt == '0) begin
            w_state_next = DONE;
          end
        end else if (r_op == OP_DIV) begin
          if (r_b == '0 || r_rem < r_b) begin
            w_state_next = DONE;
          end
        end else begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the granted operation, then do one add or subtract
  // step per RUN cycle. Everything holds while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_op   <= 2'b00;
      r_add  <= '0;
      r_cnt  <= '0;
      r_b    <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_prd  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_last <= w_gnt1;
            r_id   <= w_gnt1;
            r_op   <= w_sel_op;
            r_add  <= w_mul_add;
            r_cnt  <= w_mul_cnt;
            r_b    <= w_sel_b;
            r_quo  <= '0;
            r_rem  <= (w_sel_op == OP_DIV) ? w_sel_a : '0;
            r_prd  <= '0;
            r_err  <= 1'b0;
          end
        end
        RUN: begin
          case (r_op)
            OP_MUL: begin
              if (r_cnt != '0) begin
                r_prd <= r_prd + {{W{1'b0}}, r_add};
                r_cnt <= r_cnt - ONE_W;
              end
            end
            OP_DIV: begin
              if (r_b == '0) begin
                r_err <= 1'b1;
              end else if (r_rem >= r_b) begin
                r_rem <= r_rem - r_b;
                r_quo <= r_quo + ONE_W;
              end
            end
            default: begin
              r_err <= 1'b1;
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  // Response fields are only driven while a result is presented, so the
  // port reads all-zero whenever rsp_valid is low.
  assign rsp_valid = (r_state == DONE);
  assign rsp_id    = rsp_valid & r_id;
  assign rsp_prd   = rsp_valid ? r_prd : '0;
  assign rsp_quo   = rsp_valid ? r_quo : '0;
  assign rsp_rem   = rsp_valid ? r_rem : '0;
  assign rsp_err   = rsp_valid & r_err;

endmodule

// File: tb/tb_minialu_arb.sv
// Self-checking bench for minialu_arb: directed vector table, hand-written
// stall / mid-run reset sequences, and randomized two-requester traffic
// checked against an arithmetic reference model.
module tb_minialu_arb;

  localparam int W = 8;
`ifdef MINIALU_ARB_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           r0_valid, r0_ready, r1_valid, r1_ready;
  logic [1:0]     r0_op, r1_op;
  logic [W-1:0]   r0_a, r0_b, r1_a, r1_b;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [2*W-1:0] rsp_prd;
  logic [W-1:0]   rsp_quo, rsp_rem;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  minialu_arb #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_prd(rsp_prd), .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id; int prd; int quo; int rem; int err; int lat; int acc;
  } exp_t;

  typedef struct {
    logic         id;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int prd; int quo; int rem; int err; int lat;
  } vec_t;

  exp_t sb[$];

  // results captured by single()
  bit   cap_ok;
  int   cap_id, cap_prd, cap_quo, cap_rem, cap_err, cap_lat, cap_acc, cap_wait;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive(input int id, input logic v, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      r0_valid = v; r0_op = op; r0_a = a; r0_b = b;
    end else begin
      r1_valid = v; r1_op = op; r1_a = a; r1_b = b;
    end
  endtask

  // Reference: results from plain arithmetic; latency from the documented
  // step counts (multiply: counter+2, divide: quotient+2, error cases: 2).
  function automatic exp_t model(input int id, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    int ai, bi;
    ai = int'(a); bi = int'(b);
    e.id = id; e.prd = 0; e.quo = 0; e.rem = 0; e.err = 0; e.acc = acc; e.lat = 2;
    if (op == 2'b10) begin
      e.prd = ai * bi;
      e.lat = ((SWAP && ai < bi) ? ai : bi) + 2;
    end else if (op == 2'b11) begin
      if (bi == 0) begin
        e.err = 1; e.rem = ai;
      end else begin
        e.quo = ai / bi; e.rem = ai % bi; e.lat = e.quo + 2;
      end
    end else begin
      e.err = 1;
    end
    return e;
  endfunction

  task automatic gen_op(output logic [1:0] op, output logic [W-1:0] a, output logic [W-1:0] b);
    int s;
    s = $urandom_range(0, 9);
    if (s < 4) op = 2'b10;
    else if (s < 8) op = 2'b11;
    else op = 2'(s - 8);
    a = W'($urandom_range(0, 255));
    if ($urandom_range(0, 2) == 0) b = W'($urandom_range(0, 255));
    else b = W'($urandom_range(0, 9));
  endtask

  // One operation from one requester; entered and left at posedge+1.
  task automatic single(input int id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    acc = 0; cap_ok = 0; cap_acc = 0; cap_wait = 0;
    drive(id, 1'b1, op, a, b);
    for (int n = 0; n < 600 && !acc; n++) begin
      @(negedge clk);
      if ((id == 0) ? r0_ready : r1_ready) begin
        acc = 1; cap_acc = cyc;
      end else begin
        cap_wait++;
      end
      @(posedge clk); #1;
    end
    drive(id, 1'b0, 2'b00, '0, '0);
    chk("accept_seen", acc, 1);
    if (acc) begin
      for (int n = 0; n < 400 && !cap_ok; n++) begin
        @(negedge clk);
        if (rsp_valid) begin
          cap_ok = 1; cap_lat = cyc - cap_acc;
          cap_id = rsp_id; cap_prd = rsp_prd; cap_quo = rsp_quo; cap_rem = rsp_rem; cap_err = rsp_err;
        end
        @(posedge clk); #1;
      end
      chk("rsp_seen", cap_ok, 1);
      $display("txn id=%0d op=%0d a=%0d b=%0d -> prd=%0d quo=%0d rem=%0d err=%0d lat=%0d",
               id, op, a, b, cap_prd, cap_quo, cap_rem, cap_err, cap_lat);
    end
  endtask

  // Cycle-by-cycle traffic from both requesters with a scoreboard.
  task automatic traffic(input int nops, input bit rnd);
    int left[2];
    bit v[2];
    logic [1:0] op[2];
    logic [W-1:0] a[2], b[2];
    int last, prev, grants, win;
    bit busy, held, g0, g1;
    int h_prd, h_quo, h_rem, h_id, h_err;
    exp_t e;
    left[0] = nops; left[1] = nops; v[0] = 0; v[1] = 0;
    op[0] = 2'b00; op[1] = 2'b00; a[0] = '0; a[1] = '0; b[0] = '0; b[1] = '0;
    last = 1; prev = -1; grants = 0; busy = 0; held = 0;
    h_prd = 0; h_quo = 0; h_rem = 0; h_id = 0; h_err = 0;
    sb.delete();
    for (int n = 0; n < 40000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && left[i] > 0 && (!rnd || $urandom_range(0, 3) == 0)) begin
          gen_op(op[i], a[i], b[i]);
          v[i] = 1; left[i]--;
        end
        drive(i, v[i], op[i], a[i], b[i]);
      end
      rsp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      g0 = r0_ready; g1 = r1_ready; win = -1;
      if (!busy && (v[0] || v[1])) chk("grant_when_free", g0 | g1, 1);
      if (g0 | g1) begin
        chk("one_ready", g0 & g1, 0);
        chk("ready_while_busy", busy, 0);
        chk("ready_has_valid", g1 ? v[1] : v[0], 1);
        win = (v[0] && v[1]) ? 1 - last : (v[0] ? 0 : 1);
        chk("winner", g1, win);
        if (!rnd && prev >= 0) chk("alternate", win, 1 - prev);
        sb.push_back(model(win, op[win], a[win], b[win], cyc));
        busy = 1; last = win; prev = win; grants++;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sb[0];
          if (!held) begin
            chk("latency", cyc - e.acc, e.lat);
          end else begin
            chk("hold_prd", rsp_prd, h_prd);
            chk("hold_quo", rsp_quo, h_quo);
            chk("hold_rem", rsp_rem, h_rem);
            chk("hold_id", rsp_id, h_id);
            chk("hold_err", rsp_err, h_err);
          end
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_prd", rsp_prd, e.prd);
          chk("rsp_quo", rsp_quo, e.quo);
          chk("rsp_rem", rsp_rem, e.rem);
          chk("rsp_err", rsp_err, e.err);
          if (rsp_ready) begin
            $display("txn id=%0d prd=%0d quo=%0d rem=%0d err=%0d lat=%0d",
                     rsp_id, rsp_prd, rsp_quo, rsp_rem, rsp_err, cyc - e.acc);
            void'(sb.pop_front());
            busy = 0; held = 0;
          end else begin
            held = 1;
            h_prd = rsp_prd; h_quo = rsp_quo; h_rem = rsp_rem; h_id = rsp_id; h_err = rsp_err;
          end
        end
      end else if (held) begin
        chk("rsp_dropped", rsp_valid, 1);
        held = 0;
      end
      @(posedge clk); #1;
      if (win >= 0) v[win] = 0;
      if (left[0] == 0 && left[1] == 0 && !v[0] && !v[1] && !busy) break;
    end
    drive(0, 1'b0, 2'b00, '0, '0);
    drive(1, 1'b0, 2'b00, '0, '0);
    rsp_ready = 1'b1;
    chk("traffic_drained", left[0] + left[1] + int'(v[0]) + int'(v[1]) + int'(busy), 0);
    chk("grant_count", grants, 2 * nops);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, 2'b00, '0, '0);
    drive(1, 1'b0, 2'b00, '0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t tv[13];

  initial begin
    tv[0]  = '{1'b0, 2'b10, 8'd47,  8'd7,   329,   0,   0, 0, 9};
    tv[1]  = '{1'b1, 2'b11, 8'd7,   8'd2,   0,     3,   1, 0, 5};
    tv[2]  = '{1'b1, 2'b11, 8'd5,   8'd0,   0,     0,   5, 1, 2};
    tv[3]  = '{1'b0, 2'b00, 8'd9,   8'd9,   0,     0,   0, 1, 2};
    tv[4]  = '{1'b1, 2'b01, 8'd1,   8'd2,   0,     0,   0, 1, 2};
    tv[5]  = '{1'b0, 2'b10, 8'd200, 8'd3,   600,   0,   0, 0, 5};
    tv[6]  = '{1'b1, 2'b10, 8'd3,   8'd200, 600,   0,   0, 0, SWAP ? 5 : 202};
    tv[7]  = '{1'b0, 2'b10, 8'd0,   8'd0,   0,     0,   0, 0, 2};
    tv[8]  = '{1'b1, 2'b10, 8'd255, 8'd255, 65025, 0,   0, 0, 257};
    tv[9]  = '{1'b0, 2'b11, 8'd255, 8'd1,   0,     255, 0, 0, 257};
    tv[10] = '{1'b1, 2'b11, 8'd3,   8'd7,   0,     0,   3, 0, 2};
    tv[11] = '{1'b0, 2'b11, 8'd255, 8'd255, 0,     1,   0, 0, 3};
    tv[12] = '{1'b0, 2'b10, 8'd0,   8'd200, 0,     0,   0, 0, SWAP ? 2 : 202};

    // Reset with both requesters valid: nothing may be granted or reported.
    rst = 1'b1; rsp_ready = 1'b1;
    drive(0, 1'b1, 2'b10, 8'd3, 8'd4);
    drive(1, 1'b1, 2'b11, 8'd9, 8'd2);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_prd", rsp_prd, 0);
      chk("rst_rsp_quo", rsp_quo, 0);
      chk("rst_rsp_rem", rsp_rem, 0);
      chk("rst_rsp_err", rsp_err, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // Both requesters busy from reset: grants alternate starting with r0.
    traffic(4, 1'b0);

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      single(int'(tv[i].id), tv[i].op, tv[i].a, tv[i].b);
      if (cap_ok) begin
        chk("vec_id", cap_id, int'(tv[i].id));
        chk("vec_prd", cap_prd, tv[i].prd);
        chk("vec_quo", cap_quo, tv[i].quo);
        chk("vec_rem", cap_rem, tv[i].rem);
        chk("vec_err", cap_err, tv[i].err);
        chk("vec_lat", cap_lat, tv[i].lat);
      end
    end

    // Consumer stalls 3 cycles in DONE while r1 waits; r1 is granted in the
    // cycle right after the response handshake.
    begin
      int t_rel;
      t_rel = 0;
      rsp_ready = 1'b0;
      single(0, 2'b11, 8'd7, 8'd2);
      chk("stall_lat", cap_lat, 5);
      drive(1, 1'b1, 2'b10, 8'd6, 8'd2);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("stall_valid", rsp_valid, 1);
        chk("stall_quo", rsp_quo, 3);
        chk("stall_rem", rsp_rem, 1);
        chk("stall_id", rsp_id, 0);
        chk("stall_err", rsp_err, 0);
        chk("stall_r0_ready", r0_ready, 0);
        chk("stall_r1_ready", r1_ready, 0);
        t_rel = cyc;
        @(posedge clk); #1;
        if (k == 1) rsp_ready = 1'b1;
      end
      single(1, 2'b10, 8'd6, 8'd2);
      chk("regrant_cycle", cap_acc, t_rel + 1);
      chk("regrant_prd", cap_prd, 12);
      chk("regrant_id", cap_id, 1);
      chk("regrant_lat", cap_lat, SWAP ? 4 : 4);
    end

    // Reset in the 3rd RUN cycle of mul 200x3: no response, then the
    // pointer is back at 1 so r0 wins a tie.
    drive(0, 1'b1, 2'b10, 8'd200, 8'd3);
    @(negedge clk);
    chk("rr_accept", r0_ready, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, '0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rr_rst_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_no_rsp", rsp_valid, 0);
      chk("rr_prd_zero", rsp_prd, 0);
      chk("rr_err_zero", rsp_err, 0);
      @(posedge clk); #1;
    end
    drive(1, 1'b1, 2'b10, 8'd1, 8'd1);
    single(0, 2'b10, 8'd5, 8'd4);
    chk("rr_r0_wins", cap_wait, 0);
    chk("rr_r0_id", cap_id, 0);
    chk("rr_r0_prd", cap_prd, 20);
    single(1, 2'b10, 8'd1, 8'd1);
    chk("rr_r1_id", cap_id, 1);
    chk("rr_r1_prd", cap_prd, 1);

    // Randomized traffic with random consumer backpressure.
    do_reset();
    traffic(40, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
